// File: rtl/md4_round_sequencer.sv
// Iterative MD4 compression core: one shared step datapath, one step per clock.
// Accepts a block plus chaining state via start/ready and reports the new state with a done pulse.
module md4_round_sequencer #(
    parameter int ROUNDS    = 3,
    parameter bit FINAL_ADD = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         ready,
    input  logic         use_iv,
    input  logic [31:0]  chain_a,
    input  logic [31:0]  chain_b,
    input  logic [31:0]  chain_c,
    input  logic [31:0]  chain_d,
    input  logic [511:0] blk,
    output logic         busy,
    output logic         done,
    output logic [31:0]  dig_a,
    output logic [31:0]  dig_b,
    output logic [31:0]  dig_c,
    output logic [31:0]  dig_d
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [5:0] LAST_STEP = 6'(16 * ROUNDS - 1);

    logic [1:0]   state;
    logic [5:0]   cnt;
    logic [511:0] words;
    logic [31:0]  a, b, c, d;
    logic [31:0]  h0, h1, h2, h3;

    logic [1:0]   rnd;
    logic [3:0]   j;
    logic [3:0]   k;
    logic [31:0]  fval;
    logic [31:0]  kconst;
    logic [4:0]   shamt;
    logic [31:0]  w;
    logic [31:0]  t;
    logic [63:0]  dbl;
    logic [31:0]  n;

    assign rnd = cnt[5:4];
    assign j   = cnt[3:0];

    // Round-dependent boolean function, additive constant, word index and shift.
    always_comb begin
        k      = j;
        fval   = (b & c) | (~b & d);
        kconst = 32'h0000_0000;
        shamt  = 5'd3;
        case (rnd)
            2'd1: begin
                k      = {j[1:0], j[3:2]};
                fval   = (b & c) | (b & d) | (c & d);
                kconst = 32'h5A82_7999;
                case (j[1:0])
                    2'd0:    shamt = 5'd3;
                    2'd1:    shamt = 5'd5;
                    2'd2:    shamt = 5'd9;
                    default: shamt = 5'd13;
                endcase
            end
            2'd2: begin
                k      = {j[0], j[1], j[2], j[3]};
                fval   = b ^ c ^ d;
                kconst = 32'h6ED9_EBA1;
                case (j[1:0])
                    2'd0:    shamt = 5'd3;
                    2'd1:    shamt = 5'd9;
                    2'd2:    shamt = 5'd11;
                    default: shamt = 5'd15;
                endcase
            end
            default: begin
                case (j[1:0])
                    2'd0:    shamt = 5'd3;
                    2'd1:    shamt = 5'd7;
                    2'd2:    shamt = 5'd11;
                    default: shamt = 5'd19;
                endcase
            end
        endcase
    end

    // The upper half of the doubled word shifted left is the 32-bit rotate.
    assign w   = words[{k, 5'b00000} +: 32];
    assign t   = a + fval + w + kconst;
    assign dbl = {t, t} << shamt;
    assign n   = dbl[63:32];

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_RUN) || (state == ST_FIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
            words <= '0;
            a     <= 32'd0;
            b     <= 32'd0;
            c     <= 32'd0;
            d     <= 32'd0;
            h0    <= 32'd0;
            h1    <= 32'd0;
            h2    <= 32'd0;
            h3    <= 32'd0;
            dig_a <= 32'd0;
            dig_b <= 32'd0;
            dig_c <= 32'd0;
            dig_d <= 32'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        words <= blk;
                        cnt   <= 6'd0;
                        state <= ST_RUN;
                        if (use_iv) begin
                            a  <= 32'h6745_2301;
                            b  <= 32'hEFCD_AB89;
                            c  <= 32'h98BA_DCFE;
                            d  <= 32'h1032_5476;
                            h0 <= 32'h6745_2301;
                            h1 <= 32'hEFCD_AB89;
                            h2 <= 32'h98BA_DCFE;
                            h3 <= 32'h1032_5476;
                        end else begin
                            a  <= chain_a;
                            b  <= chain_b;
                            c  <= chain_c;
                            d  <= chain_d;
                            h0 <= chain_a;
                            h1 <= chain_b;
                            h2 <= chain_c;
                            h3 <= chain_d;
                        end
                    end
                end
                ST_RUN: begin
                    a   <= d;
                    b   <= n;
                    c   <= b;
                    d   <= c;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_STEP) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    if (FINAL_ADD) begin
                        dig_a <= h0 + a;
                        dig_b <= h1 + b;
                        dig_c <= h2 + c;
                        dig_d <= h3 + d;
                    end else begin
                        dig_a <= a;
                        dig_b <= b;
                        dig_c <= c;
                        dig_d <= d;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
